// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared fetch constants (NOP encoding, PC increment, default memory depth) and the per-cycle fetch action encoding
package if_stage_pkg;
  localparam logic [31:0] NOP = 32'h0;
  localparam int PC_INC = 4;
  localparam int DEFAULT_MEM_WORDS = 256;
  typedef enum logic [1:0] {ACT_RESET, ACT_FLUSH, ACT_HOLD, ACT_ADVANCE} fetch_act_e;
endpackage

// File: rtl/instr_mem.sv
// instr_mem: combinational-read instruction ROM of WORDS x WIDTH; ports addr (word index) -> data
module instr_mem import if_stage_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int WORDS = DEFAULT_MEM_WORDS,
  parameter string INIT_FILE = "instructions.hex"
) (
  input  logic [$clog2(WORDS)-1:0] addr,
  output logic [WIDTH-1:0]         data
);
  logic [WIDTH-1:0] mem [WORDS];
  assign data = mem[addr];
endmodule

// File: rtl/if_stage.sv
// if_stage: PC + IF/ID register over instr_mem; in clk,rst,freeze,branch_taken,branch_addr; out pc_id,instruction_id,valid_id (+freeze_count,flush_count with IF_PERF_COUNT_EN)
module if_stage import if_stage_pkg::*; #(
  parameter int BIT_NUMBER = 32,
  parameter int MEM_WORDS = DEFAULT_MEM_WORDS,
  parameter string INIT_FILE = "instructions.hex"
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  branch_taken,
  input  logic [BIT_NUMBER-1:0] branch_addr,
  output logic [BIT_NUMBER-1:0] pc_id,
  output logic [BIT_NUMBER-1:0] instruction_id,
`ifdef IF_PERF_COUNT_EN
  output logic                  valid_id,
  output logic [BIT_NUMBER-1:0] freeze_count,
  output logic [BIT_NUMBER-1:0] flush_count
`else
  output logic                  valid_id
`endif
);
  localparam int AW = $clog2(MEM_WORDS);
  logic [BIT_NUMBER-1:0] pc, pc_plus, fetched;
  fetch_act_e act;
  assign pc_plus = pc + BIT_NUMBER'(PC_INC);
  always_comb act = rst ? ACT_RESET : branch_taken ? ACT_FLUSH : freeze ? ACT_HOLD : ACT_ADVANCE;
  instr_mem #(.WIDTH(BIT_NUMBER), .WORDS(MEM_WORDS), .INIT_FILE(INIT_FILE)) u_mem (
    .addr(pc[AW+1:2]),
    .data(fetched)
  );
  always_ff @(posedge clk)
    if (act == ACT_RESET || act == ACT_FLUSH) begin
      pc             <= act == ACT_RESET ? '0 : branch_addr;
      pc_id          <= '0;
      instruction_id <= BIT_NUMBER'(NOP);
      valid_id       <= 1'b0;
    end else if (act == ACT_ADVANCE) begin
      pc             <= pc_plus;
      pc_id          <= pc_plus;
      instruction_id <= fetched;
      valid_id       <= 1'b1;
    end
`ifdef IF_PERF_COUNT_EN
  always_ff @(posedge clk) begin
    freeze_count <= rst ? '0 : (act == ACT_HOLD && !(&freeze_count)) ? freeze_count + 1'b1 : freeze_count;
    flush_count  <= rst ? '0 : (act == ACT_FLUSH && !(&flush_count)) ? flush_count + 1'b1 : flush_count;
  end
`endif
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: scoreboard bench for if_stage with directed fetch, stall, flush, wrap and reset vectors
module tb_if_stage;
  logic        clk = 0, rst = 1, freeze = 0, branch_taken = 0;
  logic [31:0] branch_addr = 0;
  logic [31:0] pc_id, instruction_id;
  logic        valid_id;
`ifdef IF_PERF_COUNT_EN
  logic [31:0] freeze_count, flush_count;
  logic        s_rst = 1, s_frz = 0, s_br = 0;
  logic [3:0]  s_addr = 0, s_pc, s_ins, s_fc, s_lc;
  logic        s_v;
`endif
  typedef struct packed {logic [31:0] pc; logic [31:0] ins; logic v;} exp_t;
  exp_t q[$];
  exp_t m_e;
  int checks = 0, failures = 0, step_no = 0;
  always #5 clk = ~clk;
  if_stage #(.BIT_NUMBER(32), .MEM_WORDS(256), .INIT_FILE("")) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken), .branch_addr(branch_addr),
    .pc_id(pc_id), .instruction_id(instruction_id),
`ifdef IF_PERF_COUNT_EN
    .valid_id(valid_id), .freeze_count(freeze_count), .flush_count(flush_count)
`else
    .valid_id(valid_id)
`endif
  );
`ifdef IF_PERF_COUNT_EN
  if_stage #(.BIT_NUMBER(4), .MEM_WORDS(4), .INIT_FILE("")) sat (
    .clk(clk), .rst(s_rst), .freeze(s_frz), .branch_taken(s_br), .branch_addr(s_addr),
    .pc_id(s_pc), .instruction_id(s_ins), .valid_id(s_v), .freeze_count(s_fc), .flush_count(s_lc)
  );
`endif
  function automatic logic [31:0] word(int i);
    return i == 0 ? 32'h11111111 : i == 1 ? 32'h22222222 : i == 2 ? 32'h33333333 : 32'hA0000000 | 32'(i);
  endfunction
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  task automatic step(input logic r, f, b, input logic [31:0] a, input logic [31:0] ep, ei, input logic ev);
    @(negedge clk);
    rst = r; freeze = f; branch_taken = b; branch_addr = a;
    q.push_back('{ep, ei, ev});
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      m_e = q.pop_front();
      step_no++;
      check($sformatf("pc_id@%0d", step_no), pc_id, m_e.pc);
      check($sformatf("instruction_id@%0d", step_no), instruction_id, m_e.ins);
      check($sformatf("valid_id@%0d", step_no), 32'(valid_id), 32'(m_e.v));
    end
  end
  initial begin
    for (int i = 0; i < 256; i++) dut.u_mem.mem[i] = word(i);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 32'h40, 0, 0, 0);
    step(0, 0, 0, 0, 4, word(0), 1);
    step(0, 0, 0, 0, 8, word(1), 1);
    step(0, 0, 0, 0, 12, word(2), 1);
    step(0, 0, 1, 4, 0, 0, 0);
    step(0, 0, 0, 0, 8, word(1), 1);
    step(0, 1, 0, 0, 8, word(1), 1);
    step(0, 1, 0, 0, 8, word(1), 1);
    step(0, 0, 0, 0, 12, word(2), 1);
    step(0, 1, 1, 32'h40, 0, 0, 0);
    step(0, 0, 0, 0, 32'h44, word(16), 1);
    step(0, 0, 1, 32'h400, 0, 0, 0);
    step(0, 0, 0, 0, 32'h404, word(0), 1);
    step(0, 0, 1, 32'h4B, 0, 0, 0);
    step(0, 0, 0, 0, 32'h4F, word(18), 1);
    step(0, 0, 0, 0, 32'h53, word(19), 1);
    step(0, 0, 1, 32'hFFFFFFFC, 0, 0, 0);
    step(0, 0, 0, 0, 0, word(255), 1);
    step(0, 0, 0, 0, 4, word(0), 1);
    step(0, 1, 0, 0, 4, word(0), 1);
    step(1, 1, 1, 32'h40, 0, 0, 0);
    step(0, 0, 0, 0, 4, word(0), 1);
    step(1, 0, 0, 0, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0, 0, 0, 0);
    repeat (2) step(0, 0, 1, 0, 0, 0, 0);
    @(posedge clk);
    #2;
`ifdef IF_PERF_COUNT_EN
    check("freeze_count", freeze_count, 3);
    check("flush_count", flush_count, 2);
`endif
    @(negedge clk);
    rst = 1; freeze = 0; branch_taken = 0;
`ifdef IF_PERF_COUNT_EN
    s_rst = 1;
    @(negedge clk);
    check("sat_freeze_reset", 32'(s_fc), 0);
    s_rst = 0; s_frz = 1;
    repeat (20) @(negedge clk);
    check("sat_freeze_count", 32'(s_fc), 15);
    s_frz = 0; s_br = 1;
    repeat (20) @(negedge clk);
    check("sat_flush_count", 32'(s_lc), 15);
    check("sat_freeze_hold", 32'(s_fc), 15);
    s_br = 0;
`endif
    @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
